coord_entry_ctrl: RTL and testbench
===================================

// Module: coord_entry_ctrl
// PURPOSE
//  Sequences PS/2 scan bytes through the scan_to_keys decoder and assembles one Battleship
//  coordinate entry: row letter (A..), column digit (0..), Enter to confirm.
//  Sits between the PS/2 byte receiver and the game FSM.
//  Hands the confirmed (row,col) to the game FSM over a valid/ready handshake.
// PARAMETERS
//  GRID_SIZE  10  rows/cols on the board (2..10); rows A..A+GRID_SIZE-1, cols 0..GRID_SIZE-1
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  scan_byte    in   8   byte from PS/2 receiver
//  scan_valid   in   1   1-cycle strobe, scan_byte valid; may assert back-to-back
//  short_code   out  8   registered make code driven to the scan_to_keys decoder
//  keys_code    in   36  one-hot decoder result (bit0='0'..bit9='9', bit10='a'..bit35='z')
//  Enter        in   1   decoder Enter flag
//  row          out  4   confirmed/pending row index (0=A)
//  col          out  4   confirmed/pending column index
//  coord_valid  out  1   coordinate available; held until accepted
//  coord_ready  in   1   game FSM accepts when high with coord_valid
//  entry_state  out  2   0=ROW 1=COL 2=CONF 3=OUT (for display)
//  err          out  1   1-cycle pulse: rejected key
// BEHAVIOUR
//  Reset: short_code=0, row=0, col=0, coord_valid=0, entry_state=0, err=0, all flags/last_make=0.
//  Prefix filter, on each scan_valid:
//   - 8'hE0 sets ext; 8'hF0 sets brk; both are consumed, never decoded.
//   - Any other byte with brk or ext set is discarded and clears both flags.
//     If brk was set and the byte equals last_make, last_make is cleared.
//   - Otherwise it is a make byte.
//  Typematic suppression: a make byte equal to last_make is discarded.
//   Any other make byte is stored to short_code and last_make and sets dec_pend.
//   Flags are tracked in every FSM state.
//  Decode stage: the cycle after dec_pend, keys_code/Enter are evaluated (keys_code is a
//   combinational decode of registered short_code). A new byte arriving in that same cycle
//   is latched normally. Make-to-action latency is 2 clk after scan_valid.
//  Esc (short_code==8'h76) is checked directly during evaluation; no err.
//  Key classes: letter = keys_code[10+r], r<GRID_SIZE; digit = keys_code[c], c<GRID_SIZE.
//   Index is by priority encode. Any other decode (other letters, zero vector) is "other".
//  FSM (entry_state) on an evaluated key:
//   ROW : letter -> row=r, COL; Esc -> ROW; Enter/digit/other -> err, stay.
//   COL : digit -> col=c, CONF; letter -> row=r, stay COL; Esc -> ROW;
//         Enter/other -> err, stay.
//   CONF: Enter -> coord_valid=1, OUT; digit -> col=c, stay; letter -> row=r, COL;
//         Esc -> ROW; other -> err, stay.
//   OUT : evaluated keys ignored, no err. coord_valid&coord_ready -> coord_valid=0 next
//         cycle, ROW. row/col hold their last value until overwritten.
//  row/col/coord_valid are stable while coord_valid is high. Arithmetic: 4-bit unsigned
//   indices; GRID_SIZE bounds are compared, never wrap.
//  err is asserted only in the evaluation cycle; never two consecutive cycles per key.
//  Reset mid-entry or mid-handshake returns everything to reset values immediately.
// TESTING
//  1 Hold reset, drive bytes -> all outputs stay at reset values; release -> entry_state=0.
//  2 1C F0 1C 16 F0 16 5A F0 5A -> row=0 col=1 coord_valid=1 state=3;
//    coord_ready=1 one cycle -> coord_valid=0, state=0.
//  3 23 23 23 F0 23 23 -> exactly two row acceptances (row=3 both times), no err,
//    state=1; then 46 5A -> col=9, coord_valid.
//  4 In ROW: 4B (L) -> err 1 pulse, state=0. 5A -> err; 45 -> err.
//    GRID_SIZE=5: 2B (F) -> err.
//  5 E0 75 E0 F0 75 in ROW -> no err, no state change;
//    1C 26 then 76 (Esc) in CONF -> state=0, no coord_valid.
//  6 Reach OUT with coord_ready=0 for 100 cycles, send 1C 45 5A ->
//    coord_valid stays 1, row/col unchanged; assert reset mid-OUT -> coord_valid=0.

Source files
------------

// File: rtl/coord_entry_ctrl.sv
// coord_entry_ctrl
//   Builds one Battleship coordinate entry from PS/2 scan bytes. The entry is a
//   row letter, then a column digit, then Enter to confirm. It filters the E0 and
//   F0 prefixes and typematic repeats, and sends each new make code to an external
//   scan_to_keys decoder. It then acts on the decoded key one cycle later. The
//   confirmed (row,col) is handed to the game FSM over a valid/ready handshake.
// Ports
//   i_clk, i_reset     clock, asynchronous active-high reset
//   i_scan_byte/valid  byte strobe from the PS/2 receiver (back-to-back allowed)
//   o_short_code       registered make code fed to the decoder
//   i_keys_code        one-hot decode: [9:0] digits '0'..'9', [35:10] letters 'a'..'z'
//   i_enter            decoder Enter flag
//   o_row, o_col       pending/confirmed indices (row 0 = A)
//   o_coord_valid      coordinate offered, held until i_coord_ready
//   o_entry_state      0=ROW 1=COL 2=CONF 3=OUT
//   o_err              single-cycle pulse for a rejected key (evaluation cycle)
module coord_entry_ctrl #(
  parameter int GRID_SIZE = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_scan_byte,
  input  logic        i_scan_valid,
  output logic [7:0]  o_short_code,
  input  logic [35:0] i_keys_code,
  input  logic        i_enter,
  output logic [3:0]  o_row,
  output logic [3:0]  o_col,
  output logic        o_coord_valid,
  input  logic        i_coord_ready,
  output logic [1:0]  o_entry_state,
  output logic        o_err
);

  localparam logic [1:0] ST_ROW  = 2'd0;
  localparam logic [1:0] ST_COL  = 2'd1;
  localparam logic [1:0] ST_CONF = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_ESC = 8'h76;

  logic       r_ext, r_brk, r_dec_pend, r_valid;
  logic [7:0] r_last_make, r_short;
  logic [1:0] r_state;
  logic [3:0] r_row, r_col;

  logic       w_letter, w_digit, w_esc, w_err, w_nvalid;
  logic [3:0] w_r, w_c, w_nrow, w_ncol;
  logic [1:0] w_nstate;

  // Priority encode within the on-board range. Scanning downward lets the lowest
  // set index win. Letters or digits beyond GRID_SIZE are never seen, so they
  // fall into "other".
  always_comb begin
    w_letter = 1'b0;
    w_digit  = 1'b0;
    w_r      = 4'd0;
    w_c      = 4'd0;
    for (int i = GRID_SIZE - 1; i >= 0; i--) begin
      if (i_keys_code[10 + i]) begin
        w_letter = 1'b1;
        w_r      = 4'(i);
      end
      if (i_keys_code[i]) begin
        w_digit = 1'b1;
        w_c     = 4'(i);
      end
    end
  end

  // Esc has no bit in the decoder output, so compare the raw make code.
  assign w_esc = (r_short == SC_ESC);

  // Entry FSM. A key is evaluated only in the cycle after a make is latched
  // (r_dec_pend). In OUT the state waits for the handshake and ignores keys.
  always_comb begin
    w_nstate = r_state;
    w_nrow   = r_row;
    w_ncol   = r_col;
    w_nvalid = r_valid;
    w_err    = 1'b0;
    if (r_state == ST_OUT) begin
      if (r_valid && i_coord_ready) begin
        w_nvalid = 1'b0;
        w_nstate = ST_ROW;
      end
    end else if (r_dec_pend) begin
      if (w_esc) begin
        w_nstate = ST_ROW;
      end else begin
        case (r_state)
          ST_ROW: begin
            if (w_letter) begin
              w_nrow   = w_r;
              w_nstate = ST_COL;
            end else begin
              w_err = 1'b1;
            end
          end
          ST_COL: begin
            if (w_digit) begin
              w_ncol   = w_c;
              w_nstate = ST_CONF;
            end else if (w_letter) begin
              w_nrow = w_r;
            end else begin
              w_err = 1'b1;
            end
          end
          default: begin // ST_CONF
            if (i_enter) begin
              w_nvalid = 1'b1;
              w_nstate = ST_OUT;
            end else if (w_digit) begin
              w_ncol = w_c;
            end else if (w_letter) begin
              w_nrow   = w_r;
              w_nstate = ST_COL;
            end else begin
              w_err = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_last_make <= 8'h00;
      r_short     <= 8'h00;
      r_dec_pend  <= 1'b0;
      r_state     <= ST_ROW;
      r_row       <= 4'd0;
      r_col       <= 4'd0;
      r_valid     <= 1'b0;
    end else begin
      r_dec_pend <= 1'b0;
      if (i_scan_valid) begin
        if (i_scan_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (i_scan_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else if (r_brk || r_ext) begin
          // Prefixed byte: a release (or an extended key) is never decoded.
          // Releasing the held key re-arms the typematic filter.
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (r_brk && (i_scan_byte == r_last_make))
            r_last_make <= 8'h00;
        end else if (i_scan_byte != r_last_make) begin
          r_short     <= i_scan_byte;
          r_last_make <= i_scan_byte;
          r_dec_pend  <= 1'b1;
        end
      end
      r_state <= w_nstate;
      r_row   <= w_nrow;
      r_col   <= w_ncol;
      r_valid <= w_nvalid;
    end
  end

  assign o_short_code  = r_short;
  assign o_row         = r_row;
  assign o_col         = r_col;
  assign o_coord_valid = r_valid;
  assign o_entry_state = r_state;
  assign o_err         = w_err;

endmodule

// File: tb/tb_coord_entry_ctrl.sv
module tb_coord_entry_ctrl;

  // Scan-set-2 codes: index 0..9 = '0'..'9', 10..35 = 'a'..'z'
  localparam logic [7:0] KTAB [0:35] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  scan_byte = 8'h00, sb5 = 8'h00;
  logic        scan_valid = 1'b0, sv5 = 1'b0;
  logic        coord_ready = 1'b0;
  logic [7:0]  short_code, short5;
  logic [35:0] keys_code, keys5;
  logic        enter, enter5;
  logic [3:0]  row, col, row5, col5;
  logic        coord_valid, valid5;
  logic [1:0]  entry_state, state5;
  logic        err, err5;

  always #5 clk = ~clk;

  // Behavioural scan_to_keys decoder
  function automatic logic [36:0] dec(input logic [7:0] sc);
    logic [36:0] d;
    d = '0;
    for (int i = 0; i < 36; i++) if (KTAB[i] == sc) d[i] = 1'b1;
    d[36] = (sc == 8'h5A);
    return d;
  endfunction

  always_comb {enter, keys_code}   = dec(short_code);
  always_comb {enter5, keys5}      = dec(short5);

  coord_entry_ctrl #(.GRID_SIZE(10)) dut (
    .i_clk(clk), .i_reset(reset), .i_scan_byte(scan_byte), .i_scan_valid(scan_valid),
    .o_short_code(short_code), .i_keys_code(keys_code), .i_enter(enter),
    .o_row(row), .o_col(col), .o_coord_valid(coord_valid), .i_coord_ready(coord_ready),
    .o_entry_state(entry_state), .o_err(err));

  coord_entry_ctrl #(.GRID_SIZE(5)) dut5 (
    .i_clk(clk), .i_reset(reset), .i_scan_byte(sb5), .i_scan_valid(sv5),
    .o_short_code(short5), .i_keys_code(keys5), .i_enter(enter5),
    .o_row(row5), .o_col(col5), .o_coord_valid(valid5), .i_coord_ready(1'b0),
    .o_entry_state(state5), .o_err(err5));

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: err expected in the evaluation cycle, state one cycle later
  typedef struct {
    int         due;
    logic       err;
    logic [1:0] st;
    logic [3:0] row, col;
    logic       v;
  } rec_t;
  rec_t errq[$], stq[$];

  // Reference model of the entry (GRID_SIZE = 10)
  logic       m_ext = 0, m_brk = 0, m_v = 0;
  logic [7:0] m_last = 0;
  logic [1:0] m_st = 0;
  logic [3:0] m_row = 0, m_col = 0;

  task automatic model_key(input logic [7:0] b, output logic er);
    int  idx;
    bit  isl, isd;
    idx = -1;
    er  = 1'b0;
    for (int i = 0; i < 36; i++) if (KTAB[i] == b) idx = i;
    isl = (idx >= 10) && (idx - 10 < 10);
    isd = (idx >= 0) && (idx < 10);
    if (m_st == 2'd3) return;
    if (b == 8'h76) begin m_st = 2'd0; return; end
    case (m_st)
      2'd0: if (isl) begin m_row = 4'(idx - 10); m_st = 2'd1; end else er = 1'b1;
      2'd1: if (isd) begin m_col = 4'(idx); m_st = 2'd2; end
            else if (isl) m_row = 4'(idx - 10);
            else er = 1'b1;
      default: if (b == 8'h5A) begin m_v = 1'b1; m_st = 2'd3; end
               else if (isd) m_col = 4'(idx);
               else if (isl) begin m_row = 4'(idx - 10); m_st = 2'd1; end
               else er = 1'b1;
    endcase
  endtask

  task automatic model_byte(input logic [7:0] b, output logic er);
    er = 1'b0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_ext || m_brk) begin
      if (m_brk && b == m_last) m_last = 8'h00;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b != m_last) begin
      m_last = b;
      model_key(b, er);
    end
  endtask

  // Called at a negedge; returns at the next negedge, so calls chain back-to-back.
  task automatic send(input logic [7:0] b);
    rec_t r;
    logic er;
    scan_byte  = b;
    scan_valid = 1'b1;
    model_byte(b, er);
    r = '{due: cyc + 1, err: er, st: m_st, row: m_row, col: m_col, v: m_v};
    errq.push_back(r);
    r.due = cyc + 2;
    stq.push_back(r);
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic ack();
    rec_t r;
    coord_ready = 1'b1;
    if (m_v) begin m_v = 1'b0; m_st = 2'd0; end
    r = '{due: cyc + 1, err: 1'b0, st: m_st, row: m_row, col: m_col, v: m_v};
    stq.push_back(r);
    @(negedge clk);
    coord_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (errq.size() > 0 && errq[0].due == cyc) begin
      chk("err", err, errq[0].err);
      void'(errq.pop_front());
    end
    if (stq.size() > 0 && stq[0].due == cyc) begin
      chk("state", entry_state, stq[0].st);
      chk("row", row, stq[0].row);
      chk("col", col, stq[0].col);
      chk("valid", coord_valid, stq[0].v);
      void'(stq.pop_front());
    end
  end

  int errs_seen = 0;
  always @(negedge clk) if (err) errs_seen <= errs_seen + 1;

  initial begin
    logic [7:0] rb [0:3];
    int e0;
    rb = '{8'h1C, 8'h16, 8'h5A, 8'h23};
    // 1: bytes under reset are ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      scan_byte = rb[i]; scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      chk("rst_short", short_code, 8'h00);
      chk("rst_out", {row, col, coord_valid, entry_state, err}, 12'h000);
    end
    reset = 1'b0;
    idle(2);
    chk("rel_state", entry_state, 2'd0);

    // GRID_SIZE=5 instance: F out of range, D accepted, 9/5 out of range, 4 accepted
    sb5 = 8'h2B; sv5 = 1'b1; @(negedge clk); sv5 = 1'b0;
    chk("g5_err_F", err5, 1'b1);
    @(negedge clk);
    chk("g5_st_F", {state5, err5}, 3'b000);
    sb5 = 8'h23; sv5 = 1'b1; @(negedge clk); sv5 = 1'b0;
    chk("g5_err_D", err5, 1'b0);
    @(negedge clk);
    chk("g5_row_D", {state5, row5}, {2'd1, 4'd3});
    sb5 = 8'h46; sv5 = 1'b1; @(negedge clk); sv5 = 1'b0;
    chk("g5_err_9", err5, 1'b1);
    sb5 = 8'h2E; sv5 = 1'b1; @(negedge clk); sv5 = 1'b0;
    chk("g5_err_5", err5, 1'b1);
    sb5 = 8'h25; sv5 = 1'b1; @(negedge clk); sv5 = 1'b0;
    chk("g5_err_4", err5, 1'b0);
    @(negedge clk);
    chk("g5_col_4", {state5, col5}, {2'd2, 4'd4});

    // 2: A, release, 1, release, Enter, release
    send(8'h1C);
    chk("short_1C", short_code, 8'h1C);
    send(8'hF0); send(8'h1C); send(8'h16); send(8'hF0); send(8'h16);
    send(8'h5A); send(8'hF0); send(8'h5A);
    idle(2);
    chk("t2_coord", {row, col, coord_valid, entry_state}, {4'd0, 4'd1, 1'b1, 2'd3});
    ack();
    idle(1);
    chk("t2_ack", {coord_valid, entry_state}, 3'b000);

    // 3: typematic D repeats, then release and re-press
    e0 = errs_seen;
    send(8'h23); send(8'h23); send(8'h23); send(8'hF0); send(8'h23); send(8'h23);
    idle(2);
    chk("t3_noerr", errs_seen - e0, 0);
    chk("t3_row", {entry_state, row}, {2'd1, 4'd3});
    send(8'h46); send(8'h5A);
    idle(2);
    chk("t3_coord", {col, coord_valid}, {4'd9, 1'b1});
    ack();
    idle(1);

    // 4: rejected keys in ROW
    e0 = errs_seen;
    send(8'h4B); send(8'h5A); send(8'h45);
    idle(2);
    chk("t4_errcnt", errs_seen - e0, 3);
    chk("t4_state", entry_state, 2'd0);

    // 5: extended keys ignored; Esc from CONF
    e0 = errs_seen;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    idle(2);
    chk("t5_ext_noerr", errs_seen - e0, 0);
    send(8'h1C); send(8'h26);
    idle(1);
    chk("t5_conf", entry_state, 2'd2);
    send(8'h76);
    idle(2);
    chk("t5_esc", {entry_state, coord_valid}, 3'b000);

    // 6: hold in OUT, keys ignored, then reset mid-handshake
    send(8'h1C); send(8'h45); send(8'h5A);
    idle(100);
    e0 = errs_seen;
    send(8'h1C); send(8'h45); send(8'h5A);
    idle(3);
    chk("t6_hold", {row, col, coord_valid, entry_state}, {4'd0, 4'd0, 1'b1, 2'd3});
    chk("t6_noerr", errs_seen - e0, 0);
    #1 reset = 1'b1;
    #1 chk("t6_rst", {coord_valid, entry_state, row, col}, 11'h0);
    @(negedge clk);
    reset = 1'b0;

    idle(3);
    chk("q_drain", errq.size() + stq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
